// File: rtl/bluetooth_tx.sv
// 8N1 UART transmitter for the Bluetooth serial link.
// A small FIFO absorbs bursts; the FSM drains it one frame at a time.
module bluetooth_tx #(
  parameter int CLKS_PER_BIT = 10415,
  parameter int FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy,
  output logic       fifo_full,
  output logic       fifo_empty
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [14:0] BAUD_MAX =
    15'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_CNT =
    (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push;
  logic               pop;

  state_t      state;
  state_t      state_n;
  logic [7:0]  shift;
  logic [7:0]  shift_n;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_n;
  logic [14:0] baud;
  logic [14:0] baud_n;
  logic        tick;
  logic        txd_n;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign tx_ready   = !fifo_full;
  assign push       = tx_valid && tx_ready;
  assign busy       = (state != IDLE) || !fifo_empty;
  assign tick       = (baud == BAUD_MAX);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n   = bit_idx;
    baud_n  = baud;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        if (!fifo_empty) begin
          shift_n = mem[rd_ptr];
          pop     = 1'b1;
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_n = {1'b0, shift[7:1]};
          bit_n   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_n = IDLE;
        end
      end
    endcase
    if (state != IDLE) begin
      baud_n = tick ? '0 : baud + 1'b1;
    end
  end

  // Line level follows the next state so edges land on bit boundaries.
  always_comb begin
    txd_n = 1'b1;
    unique case (state_n)
      IDLE:  txd_n = 1'b1;
      START: txd_n = 1'b0;
      DATA:  txd_n = shift_n[0];
      STOP:  txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      baud    <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_idx <= bit_n;
      baud    <= baud_n;
      txd     <= txd_n;
    end
  end

endmodule

// File: tb/tb_bluetooth_tx.sv
// Bench for bluetooth_tx: line monitor decodes frames against a
// scoreboard of expected 10-bit frames, plus timing corner cases.
module tb_bluetooth_tx;

  localparam int CPB = 16;
  localparam int AW  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       txd;
  logic       busy;
  logic       fifo_full;
  logic       fifo_empty;

  bluetooth_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .txd(txd),
    .busy(busy),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          vec = 0;
  int          errs = 0;
  logic [9:0]  sb[$];
  int          frames = 0;
  int          last_fall = 0;
  bit          gap_en = 1'b0;
  int          gaps[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name,
                       input int act,
                       input int exp);
    vec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  function automatic logic [9:0] fr(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  // Decode frames off txd, one sample per clock on the falling edge.
  initial begin : monitor
    logic       prev;
    int         run;
    int         gap;
    logic [9:0] f;
    bit         ok;
    bit         abort;
    prev = 1'b1;
    run  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
        run  = 0;
      end else if (prev && !txd) begin
        gap = run;
        last_fall = cyc;
        f = '1;
        ok = 1'b1;
        abort = 1'b0;
        for (int k = 0; k < 10 * CPB; k++) begin
          if (k > 0) @(negedge clk);
          if (reset) begin
            abort = 1'b1;
            break;
          end
          if (k % CPB == 0) f[k / CPB] = txd;
          else if (txd != f[k / CPB]) ok = 1'b0;
          run = txd ? run + 1 : 0;
        end
        if (abort) begin
          prev = 1'b1;
          run  = 0;
        end else begin
          frames++;
          prev = txd;
          if (gap_en) gaps.push_back(gap);
          check("bit_width", int'(ok), 1);
          if (sb.size() == 0) begin
            vec++;
            errs++;
            $display("FAIL frame: got 0x%0h, expected none", f);
          end else begin
            check("frame", int'(f), int'(sb.pop_front()));
          end
        end
      end else begin
        run = txd ? run + 1 : 0;
        prev = txd;
      end
    end
  end

  task automatic push(input logic [7:0] d,
                      input logic [9:0] f,
                      output int acc);
    int g;
    g = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (!tx_ready) begin
      vec++;
      errs++;
      $display("FAIL push_timeout: tx_ready got 0, expected 1");
      tx_valid = 1'b0;
      acc = cyc;
    end else begin
      sb.push_back(f);
      @(negedge clk);
      acc = cyc;
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(output int t);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (busy && g < 5000);
    if (busy) begin
      vec++;
      errs++;
      $display("FAIL idle_timeout: busy got 1, expected 0");
    end
    t = cyc;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation got no end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a;
    int t;
    int f0;
    int lows;
    int i;
    int g;
    int bacc[6];

    tbl[0] = '{8'h35, 10'b1001101010};
    tbl[1] = '{8'h00, 10'b1000000000};
    tbl[2] = '{8'hFF, 10'b1111111110};
    tbl[3] = '{8'hA5, 10'b1101001010};
    tbl[4] = '{8'h5A, 10'b1010110100};
    tbl[5] = '{8'h80, 10'b1100000000};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_txd", int'(txd), 1);
    check("rst_empty", int'(fifo_empty), 1);
    check("rst_full", int'(fifo_full), 0);
    check("rst_ready", int'(tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_txd", int'(txd), 1);

    // single byte timing
    push(8'h35, fr(8'h35), a);
    wait_idle(t);
    check("start_latency", last_fall - a, 1);
    check("busy_fall", t - a, 161);

    // table vectors
    for (int v = 0; v < 6; v++) begin
      push(tbl[v].data, tbl[v].frame, a);
      wait_idle(t);
      check("tbl_busy_fall", t - a, 161);
    end
    check("tbl_drained", sb.size(), 0);

    // burst until full
    gaps.delete();
    gap_en = 1'b1;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h01;
    i = 0;
    g = 0;
    while (i < 6 && g < 5000) begin
      if (tx_ready) begin
        sb.push_back(fr(tx_data));
        @(negedge clk);
        bacc[i] = cyc;
        i++;
        if (i == 4) check("full_after4", int'(fifo_full), 0);
        if (i == 5) check("full_after5", int'(fifo_full), 1);
        tx_data = 8'(i + 1);
      end else begin
        @(negedge clk);
        g++;
      end
    end
    tx_valid = 1'b0;
    check("burst_accepted", i, 6);
    if (i == 6) begin
      check("burst_consec", bacc[4] - bacc[0], 4);
      check("ready_stall", bacc[5] - bacc[4], 159);
    end
    wait_idle(t);
    gap_en = 1'b0;
    check("gap_count", gaps.size(), 6);
    if (gaps.size() == 6) begin
      for (int j = 1; j < 6; j++) check("frame_gap", gaps[j], 17);
    end
    check("burst_drained", sb.size(), 0);

    // push and pop in the same cycle
    push(8'h3C, fr(8'h3C), a);
    push(8'hC3, fr(8'hC3), t);
    while (cyc < a + 161) @(negedge clk);
    check("one_queued", int'(fifo_empty), 0);
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    sb.push_back(fr(8'hAA));
    @(negedge clk);
    tx_valid = 1'b0;
    check("pushpop_empty", int'(fifo_empty), 0);
    check("pushpop_full", int'(fifo_full), 0);
    check("pushpop_start", int'(txd), 0);
    wait_idle(t);
    check("pushpop_drained", sb.size(), 0);

    // reset mid-frame with bytes queued
    push(8'hFF, fr(8'hFF), a);
    push(8'h11, fr(8'h11), t);
    push(8'h22, fr(8'h22), t);
    while (cyc < a + 70) @(negedge clk);
    reset = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_txd", int'(txd), 1);
    check("mid_rst_empty", int'(fifo_empty), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(tx_ready), 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    f0 = frames;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (!txd) lows++;
    end
    check("post_rst_frames", frames - f0, 0);
    check("post_rst_lows", lows, 0);
    check("post_rst_busy", int'(busy), 0);

    // pointer wrap over 20 single pushes
    f0 = frames;
    for (int n = 0; n < 20; n++) begin
      push(8'(n), fr(8'(n)), a);
      wait_idle(t);
    end
    check("wrap_frames", frames - f0, 20);
    check("wrap_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
